// File: rtl/clock_enable_pkg.sv
// Shared types and constants for the clock-enable generator.
// The sequencer state enum, default accumulator width and loss-counter width
// live here so the top level and the channel sub-module agree on them.
package clock_enable_pkg;

  // Sequencer states: wait for PLL lock, let it settle, then run the channels.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } seq_state_e;

  localparam int ACC_W_DEFAULT = 24;
  localparam int LOST_CNT_W    = 8;

  // Saturating increment for the lock-loss counter: sticks at all-ones.
  function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] value);
    logic [LOST_CNT_W-1:0] result;
    if (value == {LOST_CNT_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + LOST_CNT_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/clock_enable_acc.sv
// Single fractional clock-enable channel.
// A phase accumulator adds inc every qualified cycle; the carry out of the
// top bit becomes a registered one-cycle ce pulse. Anything that disqualifies
// the channel (not running, disabled, or a sync request) zeroes the phase so
// the next run starts from a known alignment.
module clock_enable_acc
  import clock_enable_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             run,
  input  logic             en,
  input  logic             sync,
  input  logic [ACC_W-1:0] inc,
  output logic             ce
);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_nxt_s;
  logic             ce_r;
  logic             ce_nxt_s;
  logic [ACC_W:0]   sum_s;

  assign sum_s = {1'b0, acc_r} + {1'b0, inc};

  // Next accumulator value and carry; sync and disqualification both clear.
  always_comb begin
    acc_nxt_s = {ACC_W{1'b0}};
    ce_nxt_s  = 1'b0;
    if (run && en && !sync) begin
      acc_nxt_s = sum_s[ACC_W-1:0];
      ce_nxt_s  = sum_s[ACC_W];
    end else begin
      acc_nxt_s = {ACC_W{1'b0}};
      ce_nxt_s  = 1'b0;
    end
  end

  // Phase and pulse registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_r <= {ACC_W{1'b0}};
      ce_r  <= 1'b0;
    end else begin
      acc_r <= acc_nxt_s;
      ce_r  <= ce_nxt_s;
    end
  end

  assign ce = ce_r;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel fractional clock-enable generator.
// PLL lock is double-flopped into the CLK domain, a three-state sequencer
// requires SETTLE_CYCLES of continuous lock before enabling the channels, and
// every lock drop while running is counted (saturating). Channels are gated
// with the synchronised lock as well as the RUN state so that their outputs
// clear on the same edge that READY falls.
module clock_enable_gen
  import clock_enable_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int ACC_W         = ACC_W_DEFAULT,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    LOCK_IN,
  input  logic [NUM_CH*ACC_W-1:0] CH_INC,
  input  logic [NUM_CH-1:0]       CH_EN,
  input  logic                    SYNC,
  output logic [NUM_CH-1:0]       CE,
  output logic                    READY,
  output logic [LOST_CNT_W-1:0]   LOST_CNT
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic                  lock_ff1_r;
  logic                  lock_ff2_r;
  logic                  lock_s;
  seq_state_e            state_r;
  seq_state_e            state_nxt_s;
  logic                  ready_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic                  settle_done_s;
  logic [LOST_CNT_W-1:0] lost_cnt_r;
  logic [LOST_CNT_W-1:0] lost_cnt_nxt_s;
  logic                  run_s;
  logic                  lock_lost_s;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_ff1_r <= 1'b0;
      lock_ff2_r <= 1'b0;
    end else begin
      lock_ff1_r <= LOCK_IN;
      lock_ff2_r <= lock_ff1_r;
    end
  end

  assign lock_s        = lock_ff2_r;
  assign settle_done_s = (cnt_r == CNT_LAST);

  // Sequencer state register; READY is registered alongside it from the same next state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= WAIT_LOCK;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == RUN);
    end
  end

  // Sequencer next-state: any lock drop returns to WAIT_LOCK.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
        end else if (settle_done_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      RUN: begin
        if (lock_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOCK;
      end
    endcase
  end

  // Sequencer outputs: channel qualification and lock-loss strobe.
  always_comb begin
    run_s       = 1'b0;
    lock_lost_s = 1'b0;
    if (state_r == RUN) begin
      run_s       = lock_s;
      lock_lost_s = !lock_s;
    end else begin
      run_s       = 1'b0;
      lock_lost_s = 1'b0;
    end
  end

  // Settle counter next value: counts only while lock holds in SETTLE.
  always_comb begin
    cnt_nxt_s = {CNT_W{1'b0}};
    case (state_r)
      WAIT_LOCK: begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end
      SETTLE: begin
        if (!lock_s) begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end else if (settle_done_s) begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end
      default: begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Settle counter register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Lock-loss counter next value; reset is not a loss so it only counts RUN drops.
  always_comb begin
    lost_cnt_nxt_s = lost_cnt_r;
    if (lock_lost_s) begin
      lost_cnt_nxt_s = sat_inc(lost_cnt_r);
    end else begin
      lost_cnt_nxt_s = lost_cnt_r;
    end
  end

  // Lock-loss counter register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lost_cnt_r <= {LOST_CNT_W{1'b0}};
    end else begin
      lost_cnt_r <= lost_cnt_nxt_s;
    end
  end

  assign READY    = ready_r;
  assign LOST_CNT = lost_cnt_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_enable_acc #(
      .ACC_W (ACC_W)
    ) u_acc (
      .CLK   (CLK),
      .RESET (RESET),
      .run   (run_s),
      .en    (CH_EN[g]),
      .sync  (SYNC),
      .inc   (CH_INC[g*ACC_W +: ACC_W]),
      .ce    (CE[g])
    );
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: a scoreboard fed by a high-level model plus
// directed checks of pulse positions against the closed-form ceiling formula.
module tb_clock_enable_gen;

  localparam int NUM_CH = 4;
  localparam int ACC_W  = 8;
  localparam int SC     = 4;

  logic                    CLK = 1'b0;
  logic                    RESET;
  logic                    LOCK_IN;
  logic [NUM_CH*ACC_W-1:0] CH_INC;
  logic [NUM_CH-1:0]       CH_EN;
  logic                    SYNC;
  logic [NUM_CH-1:0]       CE;
  logic                    READY;
  logic [7:0]              LOST_CNT;

  always #5 CLK = ~CLK;

  clock_enable_gen #(
    .NUM_CH        (NUM_CH),
    .ACC_W         (ACC_W),
    .SETTLE_CYCLES (SC)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .LOCK_IN  (LOCK_IN),
    .CH_INC   (CH_INC),
    .CH_EN    (CH_EN),
    .SYNC     (SYNC),
    .CE       (CE),
    .READY    (READY),
    .LOST_CNT (LOST_CNT)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] ce;
    logic              ready;
    logic [7:0]        lost;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Model state: lock samples seen at the last two edges, length of the
  // current unbroken synchronised-lock run, and an unbounded phase per channel.
  logic              m_lp1, m_lp2, m_ready;
  int                m_hold, m_lost;
  longint            m_phase[NUM_CH];
  logic [NUM_CH-1:0] m_ce;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // True when RUN cycle c carries a pulse for a constant increment inc.
  function automatic logic is_pulse(input int c, input int inc);
    logic hit;
    hit = 1'b0;
    for (int n = 1; n <= c; n++) begin
      if (((n * (1 << ACC_W) + inc - 1) / inc) + 1 == c) hit = 1'b1;
    end
    return hit;
  endfunction

  // Predict outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    logic   run_q;
    longint old, inc;
    exp_t   e;
    if (RESET) begin
      m_lp1 = 1'b0; m_lp2 = 1'b0; m_ready = 1'b0; m_hold = 0; m_lost = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_phase[i] = 0; m_ce[i] = 1'b0; end
    end else begin
      run_q = m_ready && m_lp2;
      if (m_ready && !m_lp2) m_lost = (m_lost >= 255) ? 255 : m_lost + 1;
      if (m_lp2) begin
        if (m_hold < SC + 1) m_hold++;
      end else begin
        m_hold = 0;
      end
      m_ready = (m_hold >= SC + 1);
      for (int i = 0; i < NUM_CH; i++) begin
        inc = longint'(CH_INC[i*ACC_W +: ACC_W]);
        if (run_q && CH_EN[i] && !SYNC) begin
          old        = m_phase[i];
          m_phase[i] = m_phase[i] + inc;
          m_ce[i]    = ((m_phase[i] >> ACC_W) != (old >> ACC_W));
        end else begin
          m_phase[i] = 0;
          m_ce[i]    = 1'b0;
        end
      end
      m_lp2 = m_lp1;
      m_lp1 = LOCK_IN;
    end
    e.ce = m_ce; e.ready = m_ready; e.lost = 8'(m_lost);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic lock, input logic sync,
                       input logic [NUM_CH-1:0] en, input logic [NUM_CH*ACC_W-1:0] inc);
    @(negedge CLK);
    RESET = rst; LOCK_IN = lock; SYNC = sync; CH_EN = en; CH_INC = inc;
    model_step();
  endtask

  // Monitor: compare every registered output against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_ce", CE, e.ce);
        check("sb_ready", READY, e.ready);
        check("sb_lost_cnt", LOST_CNT, e.lost);
      end
    end
  end

  logic [NUM_CH*ACC_W-1:0] inc_d;
  initial begin
    int   ce1_cnt;
    int   low_left;
    logic found;
    logic lk;
    logic [NUM_CH-1:0]       en_r;
    logic [NUM_CH*ACC_W-1:0] inc_r;

    RESET = 1'b1; LOCK_IN = 1'b0; SYNC = 1'b0; CH_EN = '0; CH_INC = '0;
    inc_d = {8'd200, 8'd0, 8'd96, 8'd64};
    repeat (3) drive(1'b1, 1'b0, 1'b0, 4'h0, inc_d);
    @(posedge CLK); #1;
    check("reset_ready", READY, 0);
    check("reset_ce", CE, 0);
    check("reset_lost", LOST_CNT, 0);

    // Lock from reset release: READY at edge SC+3, pulses per ceiling formula.
    ce1_cnt = 0;
    for (int e = 1; e <= 270; e++) begin
      drive(1'b0, 1'b1, 1'b0, 4'hF, inc_d);
      @(posedge CLK); #1;
      if (e == SC + 2) check("ready_before_settle", READY, 0);
      if (e == SC + 3) check("ready_rise_edge", READY, 1);
      if (e >= SC + 3) begin
        check("ce0_formula", CE[0], is_pulse(e - SC - 2, 64));
        check("ce1_formula", CE[1], is_pulse(e - SC - 2, 96));
        if (e - SC - 2 >= 2 && e - SC - 2 <= 257) ce1_cnt += int'(CE[1]);
      end
    end
    check("ce1_rate_96_of_256", ce1_cnt, 96);

    // One-cycle lock drop in SETTLE at cnt = 2 forces a full re-settle.
    repeat (2) drive(1'b1, 1'b1, 1'b0, 4'hF, inc_d);
    for (int e = 1; e <= 14; e++) begin
      drive(1'b0, (e != 4), 1'b0, 4'hF, inc_d);
      @(posedge CLK); #1;
      if (e == SC + 3) check("glitch_no_early_ready", READY, 0);
      if (e == SC + 6) check("glitch_ready_not_yet", READY, 0);
      if (e == SC + 7) check("glitch_ready_rise", READY, 1);
    end

    // Repeated lock losses in RUN saturate LOST_CNT at 255.
    for (int k = 0; k < 300; k++) begin
      repeat (2) drive(1'b0, 1'b0, 1'b0, 4'hF, inc_d);
      repeat (9) drive(1'b0, 1'b1, 1'b0, 4'hF, inc_d);
      @(posedge CLK); #1;
      check("lost_cnt_count", LOST_CNT, (k + 1 > 255) ? 255 : k + 1);
      check("lost_ready_back", READY, 1);
    end

    // SYNC on a carry cycle: no pulse next cycle, phase restarts from zero.
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!found) begin
        if (((m_phase[0] + 64) >> ACC_W) != (m_phase[0] >> ACC_W)) found = 1'b1;
        else drive(1'b0, 1'b1, 1'b0, 4'hF, inc_d);
      end
    end
    check("sync_setup_found", found, 1);
    drive(1'b0, 1'b1, 1'b1, 4'hF, inc_d);
    @(posedge CLK); #1;
    check("sync_kills_carry", CE, 0);
    for (int c = 2; c <= 14; c++) begin
      drive(1'b0, 1'b1, 1'b0, 4'hF, inc_d);
      @(posedge CLK); #1;
      check("sync_ce0_phase", CE[0], is_pulse(c, 64));
      check("sync_ce1_phase", CE[1], is_pulse(c, 96));
    end

    // Reset mid-RUN with lock held high.
    drive(1'b1, 1'b1, 1'b0, 4'hF, inc_d);
    @(posedge CLK); #1;
    check("midrun_reset_ready", READY, 0);
    check("midrun_reset_ce", CE, 0);
    check("midrun_reset_lost", LOST_CNT, 0);
    for (int e = 1; e <= 8; e++) begin
      drive(1'b0, 1'b1, 1'b0, 4'hF, inc_d);
      @(posedge CLK); #1;
      if (e == SC + 2) check("rerise_not_yet", READY, 0);
      if (e == SC + 3) check("rerise_ready", READY, 1);
    end

    // Randomised traffic checked by the scoreboard only.
    low_left = 0;
    en_r  = 4'hF;
    inc_r = inc_d;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) inc_r = {$urandom(), $urandom()};
      if ($urandom_range(0, 39) == 0) en_r = 4'($urandom());
      if (low_left > 0) begin
        lk = 1'b0; low_left--;
      end else if ($urandom_range(0, 59) == 0) begin
        lk = 1'b0; low_left = $urandom_range(0, 3);
      end else begin
        lk = 1'b1;
      end
      drive(($urandom_range(0, 499) == 0), lk, ($urandom_range(0, 19) == 0), en_r, inc_r);
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
